procyon_wb_arbiter: RTL and testbench
=====================================

PROCYON_WB_ARBITER -- requirements
Module: procyon_wb_arbiter

Interface
REQ-001 SHALL have parameter OPTN_WB_DATA_WIDTH, default 32, Wishbone data width.
REQ-002 SHALL have parameter OPTN_WB_ADDR_WIDTH, default 32, Wishbone address width.
REQ-003 SHALL have one clock and an asynchronous active-low reset, ports clk and n_rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 i_m_wb_cyc  input  2  per-master cycle request; bit 0 = boot master, bit 1 = core master.
REQ-007 i_m_wb_stb  input  2  per-master strobe.
REQ-008 i_m_wb_we  input  2  per-master write enable.
REQ-009 i_m_wb_cti  input  2*3  per-master cycle type, master n at [n*3 +: 3].
REQ-010 i_m_wb_bte  input  2*2  per-master burst type, master n at [n*2 +: 2].
REQ-011 i_m_wb_sel  input  2*DATA/8  per-master byte select.
REQ-012 i_m_wb_addr  input  2*ADDR  per-master address.
REQ-013 i_m_wb_data  input  2*DATA  per-master write data.
REQ-014 o_m_wb_ack  output  2  per-master acknowledge.
REQ-015 o_m_wb_data  output  DATA  read data, broadcast to both masters.
REQ-016 o_s_wb_cyc, o_s_wb_stb, o_s_wb_we  output  1 each  slave-side controls.
REQ-017 o_s_wb_cti  output  3; o_s_wb_bte  output  2; o_s_wb_sel  output  DATA/8.
REQ-018 o_s_wb_addr  output  ADDR; o_s_wb_data  output  DATA  slave address/write data.
REQ-019 i_s_wb_ack  input  1; i_s_wb_data  input  DATA  slave acknowledge/read data.
REQ-020 o_grant  output  2  registered one-hot grant; 2'b00 = idle.

Function
REQ-021 State: grant register (IDLE, GNT0, GNT1) and last-served register (1 bit).
REQ-022 IDLE: if exactly one i_m_wb_cyc bit set, next state grants that master.
REQ-023 IDLE with both cyc set: grant the master not equal to last-served (round robin).
REQ-024 Grant takes effect the cycle after request sampled (1-cycle arbitration latency).
REQ-025 On entering GNTn, last-served SHALL be updated to n.
REQ-026 GNTn: held while i_m_wb_cyc[n]=1; transitions to IDLE the cycle after cyc[n] samples 0; no preemption, other requests ignored.
REQ-027 Minimum one IDLE cycle between any two tenures, including same-master re-request.
REQ-028 Slave outputs SHALL combinationally mux granted master's signals; in IDLE all slave outputs 0.
REQ-029 o_s_wb_cyc = granted cyc AND grant; a granted master dropping cyc deasserts o_s_wb_cyc same cycle.
REQ-030 o_m_wb_ack[n] = i_s_wb_ack AND GNTn; non-granted master ack always 0.
REQ-031 o_m_wb_data = i_s_wb_data unconditionally.
REQ-032 Bursts (cti 3'b010) pass through unchanged; grant stays until cyc drop regardless of ack count.

Reset
REQ-033 n_rst low SHALL immediately force IDLE, o_grant=0, all slave outputs 0, all acks 0.
REQ-034 Reset SHALL set last-served=1 so master 0 wins the first contended arbitration.
REQ-035 Reset mid-tenure SHALL abandon the transaction; no ack delivered after reset asserts.

Verification
REQ-036 Reset release, both cyc=1 same cycle -> o_grant=2'b01 next cycle, slave addr = master 0 addr.
REQ-037 Master 0 holds cyc 4 cycles then drops, master 1 waiting -> one IDLE cycle, then o_grant=2'b10.
REQ-038 Master 1 8-beat burst (cti 010 x7, 111), slave acks each -> 8 acks on o_m_wb_ack[1], zero on [0], grant never changes mid-burst.
REQ-039 Both masters continuously requesting single cycles -> grants alternate 01,00,10,00,01...
REQ-040 n_rst asserted while GNT1 with stb=1 -> o_s_wb_cyc=0 and o_grant=0 same cycle; after release with only master 1 requesting -> o_grant=2'b10.
REQ-041 i_s_wb_ack pulsed while IDLE -> both o_m_wb_ack bits remain 0.

Source files
------------

// File: rtl/procyon_wb_arbiter.sv
// Two-master Wishbone arbiter: a registered one-hot grant with round-robin on contention,
// and a combinational mux from the granted master onto the single slave port.
module procyon_wb_arbiter #(
  parameter int OPTN_WB_DATA_WIDTH = 32,
  parameter int OPTN_WB_ADDR_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [1:0]                      i_m_wb_cyc,
  input  logic [1:0]                      i_m_wb_stb,
  input  logic [1:0]                      i_m_wb_we,
  input  logic [2*3-1:0]                  i_m_wb_cti,
  input  logic [2*2-1:0]                  i_m_wb_bte,
  input  logic [2*OPTN_WB_DATA_WIDTH/8-1:0] i_m_wb_sel,
  input  logic [2*OPTN_WB_ADDR_WIDTH-1:0] i_m_wb_addr,
  input  logic [2*OPTN_WB_DATA_WIDTH-1:0] i_m_wb_data,
  output logic [1:0]                      o_m_wb_ack,
  output logic [OPTN_WB_DATA_WIDTH-1:0]   o_m_wb_data,
  output logic                            o_s_wb_cyc,
  output logic                            o_s_wb_stb,
  output logic                            o_s_wb_we,
  output logic [2:0]                      o_s_wb_cti,
  output logic [1:0]                      o_s_wb_bte,
  output logic [OPTN_WB_DATA_WIDTH/8-1:0] o_s_wb_sel,
  output logic [OPTN_WB_ADDR_WIDTH-1:0]   o_s_wb_addr,
  output logic [OPTN_WB_DATA_WIDTH-1:0]   o_s_wb_data,
  input  logic                            i_s_wb_ack,
  input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_s_wb_data,
  output logic [1:0]                      o_grant
);

  localparam int DW = OPTN_WB_DATA_WIDTH;
  localparam int AW = OPTN_WB_ADDR_WIDTH;
  localparam int SW = OPTN_WB_DATA_WIDTH / 8;

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        case (i_m_wb_cyc)
          2'b01:   state_d = GNT0;
          2'b10:   state_d = GNT1;
          2'b11:   state_d = last_q ? GNT0 : GNT1;
          default: state_d = IDLE;
        endcase
        if (state_d == GNT0) last_d = 1'b0;
        if (state_d == GNT1) last_d = 1'b1;
      end
      // No preemption: tenure ends only when the owner drops cyc.
      GNT0:    if (!i_m_wb_cyc[0]) state_d = IDLE;
      GNT1:    if (!i_m_wb_cyc[1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_grant     = state_q;
  assign o_m_wb_data = i_s_wb_data;

  always_comb begin
    o_s_wb_cyc  = 1'b0;
    o_s_wb_stb  = 1'b0;
    o_s_wb_we   = 1'b0;
    o_s_wb_cti  = '0;
    o_s_wb_bte  = '0;
    o_s_wb_sel  = '0;
    o_s_wb_addr = '0;
    o_s_wb_data = '0;
    o_m_wb_ack  = '0;
    for (int n = 0; n < 2; n++) begin
      if (state_q[n]) begin
        o_s_wb_cyc    = i_m_wb_cyc[n];
        o_s_wb_stb    = i_m_wb_stb[n];
        o_s_wb_we     = i_m_wb_we[n];
        o_s_wb_cti    = i_m_wb_cti[n*3 +: 3];
        o_s_wb_bte    = i_m_wb_bte[n*2 +: 2];
        o_s_wb_sel    = i_m_wb_sel[n*SW +: SW];
        o_s_wb_addr   = i_m_wb_addr[n*AW +: AW];
        o_s_wb_data   = i_m_wb_data[n*DW +: DW];
        o_m_wb_ack[n] = i_s_wb_ack;
      end
    end
  end

endmodule

// File: tb/tb_procyon_wb_arbiter.sv
// Bench for procyon_wb_arbiter: directed table, burst and reset sequences, then random
// traffic checked against an owner/last-served reference model.
module tb_procyon_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [1:0]      m_cyc, m_stb, m_we;
  logic [5:0]      m_cti;
  logic [3:0]      m_bte;
  logic [2*SW-1:0] m_sel;
  logic [2*AW-1:0] m_addr;
  logic [2*DW-1:0] m_data;
  logic [1:0]      m_ack;
  logic [DW-1:0]   m_rdata;
  logic            s_cyc, s_stb, s_we;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic [SW-1:0]   s_sel;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_ack;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      grant;

  procyon_wb_arbiter #(.OPTN_WB_DATA_WIDTH(DW), .OPTN_WB_ADDR_WIDTH(AW)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_m_wb_cyc(m_cyc), .i_m_wb_stb(m_stb), .i_m_wb_we(m_we), .i_m_wb_cti(m_cti),
    .i_m_wb_bte(m_bte), .i_m_wb_sel(m_sel), .i_m_wb_addr(m_addr), .i_m_wb_data(m_data),
    .o_m_wb_ack(m_ack), .o_m_wb_data(m_rdata),
    .o_s_wb_cyc(s_cyc), .o_s_wb_stb(s_stb), .o_s_wb_we(s_we), .o_s_wb_cti(s_cti),
    .o_s_wb_bte(s_bte), .o_s_wb_sel(s_sel), .o_s_wb_addr(s_addr), .o_s_wb_data(s_wdata),
    .i_s_wb_ack(s_ack), .i_s_wb_data(s_rdata), .o_grant(grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int own;   // -1 idle, else index of the master holding the bus
  int last;  // master served most recently

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] eg;
    eg = (own < 0) ? 2'b00 : (own == 0 ? 2'b01 : 2'b10);
    chk({tag, " grant"}, 64'(grant), 64'(eg));
    chk({tag, " mdata"}, 64'(m_rdata), 64'(s_rdata));
    if (own < 0) begin
      chk({tag, " idle ack"}, 64'(m_ack), 64'd0);
      chk({tag, " idle slave"}, {s_cyc, s_stb, s_we, s_cti, s_bte, s_sel}, 64'd0);
      chk({tag, " idle addr"}, 64'(s_addr), 64'd0);
      chk({tag, " idle wdata"}, 64'(s_wdata), 64'd0);
    end else begin
      chk({tag, " ack"}, 64'(m_ack), 64'(s_ack ? (2'b01 << own) : 2'b00));
      chk({tag, " cyc"}, 64'(s_cyc), 64'(m_cyc[own]));
      chk({tag, " ctl"}, {s_stb, s_we, s_cti, s_bte, s_sel},
          {m_stb[own], m_we[own], m_cti[own*3 +: 3], m_bte[own*2 +: 2], m_sel[own*SW +: SW]});
      chk({tag, " addr"}, 64'(s_addr), 64'(m_addr[own*AW +: AW]));
      chk({tag, " wdata"}, 64'(s_wdata), 64'(m_data[own*DW +: DW]));
    end
  endtask

  // Reference: an idle bus goes to the sole requester, or on contention to whoever was
  // not served last; an owner keeps the bus until it is seen with cyc low.
  task automatic model_step();
    if (own < 0) begin
      if (m_cyc == 2'b01) own = 0;
      else if (m_cyc == 2'b10) own = 1;
      else if (m_cyc == 2'b11) own = 1 - last;
      if (own >= 0) last = own;
    end else if (!m_cyc[own]) begin
      own = -1;
    end
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic [1:0] cyc;
    logic       ack;
    logic [1:0] g;
    logic       scyc;
    logic [1:0] mack;
  } vec_t;
  vec_t tbl[18];

  int ack0, ack1;

  initial begin
    tbl[0]  = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[1]  = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[2]  = '{2'b11, 1'b0, 2'b01, 1'b1, 2'b00};
    tbl[3]  = '{2'b11, 1'b0, 2'b01, 1'b1, 2'b00};
    tbl[4]  = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[5]  = '{2'b10, 1'b0, 2'b01, 1'b0, 2'b00};
    tbl[6]  = '{2'b10, 1'b1, 2'b00, 1'b0, 2'b00};
    tbl[7]  = '{2'b10, 1'b1, 2'b10, 1'b1, 2'b10};
    tbl[8]  = '{2'b00, 1'b0, 2'b10, 1'b0, 2'b00};
    tbl[9]  = '{2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    tbl[10] = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[11] = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[12] = '{2'b10, 1'b0, 2'b01, 1'b0, 2'b00};
    tbl[13] = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[14] = '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10};
    tbl[15] = '{2'b01, 1'b0, 2'b10, 1'b0, 2'b00};
    tbl[16] = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[17] = '{2'b11, 1'b0, 2'b01, 1'b1, 2'b00};

    n_rst = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = 2'b10; m_cti = '0; m_bte = 4'b0110;
    m_sel = 8'h3c; m_addr = {32'h2000_0004, 32'h1000_0000};
    m_data = {32'hbbbb_0001, 32'haaaa_0000};
    s_ack = 1'b0; s_rdata = 32'h5a5a_1234;
    own = -1; last = 1;
    #2;
    chk("reset grant", 64'(grant), 64'd0);
    chk("reset slave", {s_cyc, s_stb, s_we, m_ack}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      m_cyc = tbl[i].cyc;
      m_stb = tbl[i].cyc;
      s_ack = tbl[i].ack;
      @(negedge clk);
      chk($sformatf("tbl%0d grant", i), 64'(grant), 64'(tbl[i].g));
      chk($sformatf("tbl%0d scyc", i), 64'(s_cyc), 64'(tbl[i].scyc));
      chk($sformatf("tbl%0d mack", i), 64'(m_ack), 64'(tbl[i].mack));
      if (i == 1) chk("first addr m0", 64'(s_addr), 64'h1000_0000);
      check_all($sformatf("tbl%0d", i));
      @(posedge clk);
      model_step();
      #1;
    end

    // 8-beat incrementing burst from master 1
    m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0;
    step("pre-burst");
    step("pre-burst");
    m_cyc = 2'b10; m_stb = 2'b10; m_cti = 6'b010_000;
    step("burst arb");
    ack0 = 0; ack1 = 0;
    for (int b = 0; b < 8; b++) begin
      m_cti = (b == 7) ? 6'b111_000 : 6'b010_000;
      s_ack = 1'b1;
      @(negedge clk);
      ack0 += int'(m_ack[0]);
      ack1 += int'(m_ack[1]);
      chk($sformatf("burst%0d grant", b), 64'(grant), 64'(2'b10));
      check_all($sformatf("burst%0d", b));
      @(posedge clk);
      model_step();
      #1;
    end
    chk("burst acks m1", 64'(ack1), 64'd8);
    chk("burst acks m0", 64'(ack0), 64'd0);
    m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0; m_cti = '0;
    step("post-burst");
    step("post-burst");

    // Reset in the middle of a master-1 tenure
    m_cyc = 2'b10; m_stb = 2'b10;
    step("rst arb");
    step("rst gnt1");
    s_ack = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst grant", 64'(grant), 64'd0);
    chk("rst scyc", 64'(s_cyc), 64'd0);
    chk("rst ack", 64'(m_ack), 64'd0);
    own = -1; last = 1;
    @(posedge clk); #1;
    chk("rst held ack", 64'(m_ack), 64'd0);
    n_rst = 1'b1;
    s_ack = 1'b0;
    step("post-rst idle");
    @(negedge clk);
    chk("post-rst grant m1", 64'(grant), 64'(2'b10));
    @(posedge clk); model_step(); #1;
    m_cyc = 2'b00; m_stb = 2'b00;
    step("post-rst drop");

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      m_cyc[0] = ($urandom_range(0, 9) < 7);
      m_cyc[1] = ($urandom_range(0, 9) < 7);
      m_stb   = 2'($urandom);
      m_we    = 2'($urandom);
      m_cti   = 6'($urandom);
      m_bte   = 4'($urandom);
      m_sel   = 8'($urandom);
      m_addr  = {$urandom, $urandom};
      m_data  = {$urandom, $urandom};
      s_ack   = 1'($urandom);
      s_rdata = $urandom;
      step($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
